// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU memory hierarchy: the RAM status encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_arbiter_pkg.sv
// Arbiter-local types and constants for ram_arbiter.
package ram_arbiter_pkg;

    localparam int          ARB_NREQ   = 4;
    localparam logic [31:0] ARB_POISON = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side and RAM-side signals of the shared RAM port arbiter.
// slave is the arbiter's view; master is the caches/RAM environment's view.
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NREQ = ram_arbiter_pkg::ARB_NREQ
);
    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_store;
    logic [31:0]        req_load;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_wait;
    logic               ramREN;
    logic               ramWEN;
    logic [31:0]        ramaddr;
    logic [31:0]        ramstore;
    logic [31:0]        ramload;
    ramstate_t          ramstate;
    logic               arb_err;

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_load, req_done, req_wait, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport master (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_load, req_done, req_wait, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first active index at or after rr_ptr, wrapping.
module ram_arbiter_rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] active,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    int          j;
    logic [IW-1:0] j_idx;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        j_idx = '0;
        // Walk from farthest to nearest so the nearest active index wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            j_idx = IW'(j);
            if (active[j_idx]) begin
                valid = 1'b1;
                idx   = j_idx;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between all icache/dcache requesters.
// Optional per-transaction abort timer enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter
    import cpu_types_pkg::*;
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int TIMEOUT = 255
) (
    input logic          CLK,
    input logic          nRST,
    ram_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            err_q;
    logic [NREQ-1:0] active;
    logic [NREQ-1:0] done_vec;
    logic            owner_active;
    logic            owner_write;
    logic            ram_done;
    logic            timed_out;
    logic            complete;

    assign active       = bus.req_ren | bus.req_wen;
    assign owner_active = active[owner];
    assign owner_write  = bus.req_wen[owner];
    assign ram_done     = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    assign next_ptr     = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    ram_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_picker (
        .active (active),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] timer;

    // timer holds the number of GRANT cycles already spent on this owner.
    assign timed_out = (state == GRANT) && owner_active && !ram_done
                       && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!nRST)                timer <= '0;
        else if (state != GRANT)  timer <= '0;
        else                      timer <= timer + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    // An owner that dropped its enables aborts; its late ACCESS is never credited.
    assign complete = (state == GRANT) && owner_active && (ram_done || timed_out);

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        done_vec     = '0;
        bus.req_load = '0;
        if (state == GRANT) begin
            bus.ramREN   = bus.req_ren[owner] & ~owner_write;
            bus.ramWEN   = owner_write;
            bus.ramaddr  = bus.req_addr[int'(owner)*32 +: 32];
            bus.ramstore = bus.req_store[int'(owner)*32 +: 32];
        end
        if (complete) begin
            done_vec[owner] = 1'b1;
            bus.req_load    = timed_out ? ARB_POISON : bus.ramload;
        end
    end

    assign bus.req_done = done_vec;
    assign bus.req_wait = active & ~done_vec;
    assign bus.arb_err  = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_active) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (complete) begin
                        state  <= DONE;
                        rr_ptr <= next_ptr;
                        if ((bus.ramstate == ERROR) || timed_out) err_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ       = 4;
    localparam int TB_TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] a, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (a[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Reference model: who owns the port, whether a turnaround gap is due, and the fairness pointer.
    int          m_owner = -1;
    bit          m_gap   = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_err   = 1'b0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;

    always @(negedge CLK) begin : model
        logic [NREQ-1:0] act, exp_done;
        logic            exp_ren, exp_wen, o_act, rs_done, to_hit, complete;
        logic [31:0]     exp_addr, exp_store, exp_load;
        int              p;
        act       = bus.req_ren | bus.req_wen;
        exp_done  = '0;
        exp_ren   = 1'b0;
        exp_wen   = 1'b0;
        exp_addr  = '0;
        exp_store = '0;
        exp_load  = '0;
        o_act     = 1'b0;
        complete  = 1'b0;
        rs_done   = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
        to_hit    = TMO_EN && (m_cnt == TB_TIMEOUT - 1);
        if (m_owner >= 0) begin
            o_act     = act[m_owner];
            exp_wen   = bus.req_wen[m_owner];
            exp_ren   = bus.req_ren[m_owner] & ~exp_wen;
            exp_addr  = bus.req_addr[m_owner*32 +: 32];
            exp_store = bus.req_store[m_owner*32 +: 32];
            complete  = o_act && (rs_done || to_hit);
            if (complete) begin
                exp_done[m_owner] = 1'b1;
                exp_load = rs_done ? bus.ramload : 32'hBAD1_BAD1;
            end
        end
        if (m_valid) begin
            check("model ramREN",   32'(bus.ramREN),   32'(exp_ren));
            check("model ramWEN",   32'(bus.ramWEN),   32'(exp_wen));
            check("model ramaddr",  bus.ramaddr,       exp_addr);
            check("model ramstore", bus.ramstore,      exp_store);
            check("model req_done", 32'(bus.req_done), 32'(exp_done));
            check("model req_wait", 32'(bus.req_wait), 32'(act & ~exp_done));
            check("model arb_err",  32'(bus.arb_err),  32'(m_err));
            if (complete) check("model req_load", bus.req_load, exp_load);
        end
        if (!nRST) begin
            m_valid = 1'b1;
            m_owner = -1;
            m_gap   = 1'b0;
            m_err   = 1'b0;
            m_ptr   = 0;
        end else if (m_valid) begin
            if (m_owner >= 0) begin
                if (!o_act) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end else if (complete) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_err   = m_err | (bus.ramstate == ERROR) | !rs_done;
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else begin
                p = pick(act, m_ptr);
                if (p >= 0) begin
                    m_owner = p;
                    m_cnt   = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int done_cyc[$];
        int done_idx[$];
        int ord[5] = '{0, 1, 2, 3, 0};

        // Reset state: req_wait follows the raw requests even while held in reset.
        nRST = 1'b0;
        clear_inputs();
        bus.req_ren = 4'b0101;
        tick();
        tick();
        #2;
        check("reset ramREN",   32'(bus.ramREN),   32'd0);
        check("reset ramaddr",  bus.ramaddr,       32'd0);
        check("reset req_done", 32'(bus.req_done), 32'd0);
        check("reset arb_err",  32'(bus.arb_err),  32'd0);
        check("reset req_wait", 32'(bus.req_wait), 32'h5);

        // Single read through BUSY, BUSY, ACCESS.
        do_reset();
        bus.req_ren = 4'b0010;
        bus.req_addr[1*32 +: 32] = 32'h40;
        #2;
        check("t1 idle ramREN",  32'(bus.ramREN),   32'd0);
        check("t1 idle wait",    32'(bus.req_wait), 32'h2);
        tick(); bus.ramstate = BUSY; #2;
        check("t1 c1 ramREN",    32'(bus.ramREN),   32'd1);
        check("t1 c1 ramaddr",   bus.ramaddr,       32'h40);
        tick(); #2;
        check("t1 c2 req_done",  32'(bus.req_done), 32'd0);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF; #2;
        check("t1 c3 req_done",  32'(bus.req_done), 32'h2);
        check("t1 c3 req_load",  bus.req_load,      32'hDEAD_BEEF);
        check("t1 c3 req_wait",  32'(bus.req_wait), 32'd0);
        tick(); bus.req_ren = '0; bus.ramstate = FREE; #2;
        check("t1 gap ramREN",   32'(bus.ramREN),   32'd0);
        tick();

        // Round robin with all requesters active and an always-ready RAM.
        do_reset();
        bus.req_ren  = 4'b1111;
        for (int i = 0; i < NREQ; i++) bus.req_addr[i*32 +: 32] = 32'h100 + 32'(i);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h5555_AAAA;
        for (int c = 0; c < 15; c++) begin
            #2;
            for (int i = 0; i < NREQ; i++)
                if (bus.req_done[i]) begin
                    done_cyc.push_back(c);
                    done_idx.push_back(i);
                end
            tick();
        end
        clear_inputs();
        check("t2 grant count", 32'(done_idx.size()), 32'd5);
        for (int k = 0; k < 5 && k < done_idx.size(); k++) begin
            check($sformatf("t2 grant order %0d", k), 32'(done_idx[k]), 32'(ord[k]));
            check($sformatf("t2 done cycle %0d", k),  32'(done_cyc[k]), 32'(1 + 3*k));
        end
        tick();

        // Simultaneous REN and WEN resolves to a write.
        do_reset();
        bus.req_ren = 4'b0100;
        bus.req_wen = 4'b0100;
        bus.req_addr[2*32 +: 32]  = 32'h200;
        bus.req_store[2*32 +: 32] = 32'h1234;
        tick(); bus.ramstate = ACCESS; #2;
        check("t3 ramWEN",   32'(bus.ramWEN),   32'd1);
        check("t3 ramREN",   32'(bus.ramREN),   32'd0);
        check("t3 ramstore", bus.ramstore,      32'h1234);
        check("t3 req_done", 32'(bus.req_done), 32'h4);
        tick(); bus.req_ren = '0; bus.req_wen = '0; bus.ramstate = FREE;
        tick();

        // Abort: requester 3 withdraws mid-grant; next grant goes to requester 0.
        bus.req_ren = 4'b1000;
        bus.req_addr[3*32 +: 32] = 32'h300;
        bus.req_addr[0*32 +: 32] = 32'h010;
        bus.ramstate = BUSY;
        tick(); #2;
        check("t4 grant3 ramaddr", bus.ramaddr,     32'h300);
        tick(); bus.req_ren = 4'b0001; #2;
        check("t4 abort req_done", 32'(bus.req_done), 32'd0);
        tick(); #2;
        check("t4 idle ramREN",    32'(bus.ramREN),   32'd0);
        tick(); bus.ramstate = ACCESS; #2;
        check("t4 grant0 ramaddr", bus.ramaddr,       32'h010);
        check("t4 grant0 done",    32'(bus.req_done), 32'h1);
        tick(); bus.req_ren = '0; bus.ramstate = FREE;
        tick();

        // ERROR completes the handshake and sets a sticky flag.
        bus.req_ren = 4'b0010;
        tick(); bus.ramstate = ERROR; bus.ramload = 32'hCAFE_F00D; #2;
        check("t5 err req_done", 32'(bus.req_done), 32'h2);
        check("t5 err req_load", bus.req_load,      32'hCAFE_F00D);
        tick(); bus.req_ren = '0; bus.ramstate = FREE; #2;
        check("t5 arb_err set",  32'(bus.arb_err),  32'd1);
        tick(); bus.req_ren = 4'b0100;
        tick(); bus.ramstate = ACCESS; #2;
        check("t5 next done",    32'(bus.req_done), 32'h4);
        check("t5 arb_err held", 32'(bus.arb_err),  32'd1);
        tick(); bus.req_ren = '0; bus.ramstate = FREE;
        tick();

        // RAM stuck BUSY: times out when enabled, otherwise waits indefinitely.
        do_reset();
        #2;
        check("t6 arb_err cleared", 32'(bus.arb_err), 32'd0);
        bus.req_ren  = 4'b0001;
        bus.ramstate = BUSY;
        for (int g = 1; g <= 4; g++) begin
            tick(); #2;
            check($sformatf("t6 grant cycle %0d done", g), 32'(bus.req_done),
                  (TMO_EN && g == 4) ? 32'h1 : 32'h0);
        end
        if (TMO_EN) check("t6 poison load", bus.req_load, 32'hBAD1_BAD1);
        tick(); #2;
        check("t6 after ramREN",  32'(bus.ramREN),  TMO_EN ? 32'd0 : 32'd1);
        check("t6 after arb_err", 32'(bus.arb_err), 32'(TMO_EN));
        bus.req_ren = '0;
        tick();

        // Reset while granted drops the RAM enables at that edge with no completion.
        do_reset();
        bus.req_ren  = 4'b0010;
        bus.ramstate = BUSY;
        tick(); #2;
        check("t7 granted ramREN", 32'(bus.ramREN),   32'd1);
        tick(); nRST = 1'b0; bus.ramstate = ACCESS; #2;
        tick(); #2;
        check("t7 reset ramREN",   32'(bus.ramREN),   32'd0);
        check("t7 reset req_done", 32'(bus.req_done), 32'd0);
        nRST = 1'b1;
        bus.ramstate = BUSY;
        tick();
        clear_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single RAM port between the instruction-cache and data-cache requesters of every core. Sits between the caches and the RAM model/memory controller. Round-robin grant. Holds one grant until the RAM reports ACCESS, then releases it and forwards load data with a one-cycle completion strobe.

Parameters:
NREQ, 4, number of requesters (index 2k = core k icache, 2k+1 = core k dcache)
TIMEOUT, 255, RAM cycles allowed per transaction before abort (used only with ARB_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
req_ren  in  NREQ  read request per requester
req_wen  in  NREQ  write request per requester
req_addr  in  NREQ*32  word address per requester
req_store  in  NREQ*32  write data per requester
req_load  out  32  load data, shared by all requesters
req_done  out  NREQ  one-hot completion strobe
req_wait  out  NREQ  high while the requester's request is not completed
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
arb_err  out  1  sticky error flag

Behaviour:
- Reset applies only on a rising CLK edge with nRST=0. On reset: state IDLE, owner 0, rr_ptr 0, arb_err 0. All ram* outputs and req_done are 0. req_wait equals req_ren|req_wen.
- Active requester: req_ren[i]|req_wen[i]. If both are set, the access is a write.
- State IDLE:
  - Pick the first active index, searching cyclically from rr_ptr.
  - On the next edge, register it as owner and go to GRANT.
  - If no requester is active, stay in IDLE.
  - Grant latency is 1 cycle. The RAM sees the request in the first GRANT cycle.
- State GRANT:
  - ramREN/ramWEN/ramaddr/ramstore are driven combinationally from the owner's inputs.
  - Signals from non-owners are ignored.
- ramstate handling in GRANT:
  - BUSY or FREE: hold.
  - ACCESS in the same cycle:
    - req_load = ramload.
    - req_done[owner] = 1.
    - req_wait[owner] = 0.
    - Next state DONE; rr_ptr = owner+1 mod NREQ.
  - ERROR: set arb_err, treat as ACCESS for the handshake (req_load = ramload), go to DONE.
- State DONE:
  - Lasts one cycle. ram enables are 0, so the RAM sees a deassert gap.
  - Then go to IDLE. This prevents a stale ACCESS from being credited to the next owner.
- Abort: if the owner drops both enables while in GRANT, go to IDLE on the next edge with no req_done. rr_ptr still advances.
- Fairness: the requester that just completed has the lowest priority on the next arbitration. With all 4 requesters continuously active, grants go 0,1,2,3,0… and each transaction takes at least 3 cycles (IDLE, GRANT, DONE).
- req_wait[i] = active[i] & ~req_done[i], in every state.
- arb_err is cleared only by reset.
- Reset during GRANT: ram enables drop at that edge and no req_done is issued.

Optional Feature:
ARB_TIMEOUT_EN:
- When defined:
  - An 8-bit-or-wider counter clears on entry to GRANT and increments each GRANT cycle without ACCESS/ERROR.
  - When it reaches TIMEOUT: set arb_err, pulse req_done[owner] with req_load = 32'hBAD1BAD1, go to DONE.
- When undefined: no counter. GRANT waits indefinitely.

Decomposition:
- Package: arb_state_t (IDLE, GRANT, DONE), the NREQ default, and the timeout poison constant. ramstate_t is reused from cpu_types_pkg.
- One sub-module, rr_picker (purely combinational): takes the active vector and rr_ptr, returns a valid flag and the chosen index.

Test Plan:
1. Single read: req_ren[1]=1, addr 0x40; RAM gives BUSY for 2 cycles, then ACCESS with ramload=0xDEADBEEF -> ramaddr=0x40, ramREN=1 from cycle 1; req_done[1] in cycle 3 with req_load=0xDEADBEEF; then DONE, then IDLE.
2. Round-robin: all 4 requesters active, RAM gives immediate ACCESS -> grant order 0,1,2,3,0; req_done spacing 3 cycles.
3. REN+WEN on the same requester 2, store 0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
4. Abort: requester 3 drops its enables in GRANT -> IDLE next cycle, no req_done[3], next grant goes to index 0.
5. ERROR: ramstate=ERROR -> arb_err=1 and stays 1, req_done pulses, arbitration continues.
6. With ARB_TIMEOUT_EN and TIMEOUT=4, RAM stuck BUSY -> done after 4 GRANT cycles, req_load=0xBAD1BAD1, arb_err=1. nRST=0 mid-GRANT -> ram enables drop at that edge.
